// File: rtl/alu_exec_unit.sv
// Execute-stage datapath: ALU-control decode, 32-bit ALU with zero flag,
// PC+4 and branch-target adders, all captured in one enabled output register.

module wrap_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);
  // Carry-out intentionally dropped: addresses wrap modulo 2^W.
  assign sum = a + b;
endmodule

module alu_exec_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        alu_op1,
  input  logic        alu_op0,
  input  logic [5:0]  funct,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] pc,
  input  logic [31:0] branch_offset,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic [31:0] pc_plus_4,
  output logic [31:0] branch_target
);

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] result;
    logic        zero;
    logic [31:0] pc4;
    logic [31:0] target;
  } exec_res_t;

  localparam exec_res_t RES_RESET = '{ctrl: CTRL_ADD, result: 32'd0, zero: 1'b1,
                                      pc4: 32'd0, target: 32'd0};

  logic [3:0]  ctrl_c;
  logic [31:0] result_c;
  logic [31:0] pc4_c;
  logic [31:0] target_c;
  exec_res_t   res_c;
  exec_res_t   res_q;

  always_comb begin
    ctrl_c = CTRL_ADD;
    unique case ({alu_op1, alu_op0})
      2'b00: ctrl_c = CTRL_ADD;
      2'b01: ctrl_c = CTRL_SUB;
      2'b11: ctrl_c = CTRL_OR;
      2'b10: begin
        case (funct)
          6'b100000: ctrl_c = CTRL_ADD;
          6'b100010: ctrl_c = CTRL_SUB;
          6'b100100: ctrl_c = CTRL_AND;
          6'b100101: ctrl_c = CTRL_OR;
          6'b101010: ctrl_c = CTRL_SLT;
          6'b100111: ctrl_c = CTRL_NOR;
          default:   ctrl_c = CTRL_ADD;
        endcase
      end
      default: ctrl_c = CTRL_ADD;
    endcase
  end

  always_comb begin
    result_c = 32'd0;
    case (ctrl_c)
      CTRL_AND: result_c = src_a & src_b;
      CTRL_OR:  result_c = src_a | src_b;
      CTRL_ADD: result_c = src_a + src_b;
      CTRL_SUB: result_c = src_a - src_b;
      CTRL_SLT: result_c = {31'd0, $signed(src_a) < $signed(src_b)};
      CTRL_NOR: result_c = ~(src_a | src_b);
      default:  result_c = 32'd0;
    endcase
  end

  wrap_adder #(.W(32)) u_pc_add (.a(pc),    .b(32'd4),         .sum(pc4_c));
  wrap_adder #(.W(32)) u_br_add (.a(pc4_c), .b(branch_offset), .sum(target_c));

  always_comb begin
    res_c        = RES_RESET;
    res_c.ctrl   = ctrl_c;
    res_c.result = result_c;
    res_c.zero   = (result_c == 32'd0);
    res_c.pc4    = pc4_c;
    res_c.target = target_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   res_q <= RES_RESET;
    else if (en) res_q <= res_c;
  end

  assign alu_ctrl      = res_q.ctrl;
  assign alu_result    = res_q.result;
  assign zero          = res_q.zero;
  assign pc_plus_4     = res_q.pc4;
  assign branch_target = res_q.target;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: reset, R-type sweep, branch compare,
// signed SLT, PC adders and enable hold, each with hand-computed expectations.

module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        reset, en, alu_op1, alu_op0;
  logic [5:0]  funct;
  logic [31:0] src_a, src_b, pc, branch_offset;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result, pc_plus_4, branch_target;
  logic        zero;

  int n_cmp = 0;
  int n_bad = 0;

  alu_exec_unit dut (
    .clk(clk), .reset(reset), .en(en), .alu_op1(alu_op1), .alu_op0(alu_op0),
    .funct(funct), .src_a(src_a), .src_b(src_b), .pc(pc),
    .branch_offset(branch_offset), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .zero(zero), .pc_plus_4(pc_plus_4), .branch_target(branch_target)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [1:0] op, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    {alu_op1, alu_op0} = op;
    funct = f;
    src_a = a;
    src_b = b;
  endtask

  // Inputs change at the falling edge, outputs are read at the next falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [100:0] got;
    logic [100:0] rst_exp;
    rst_exp = {4'b0010, 32'd0, 1'b1, 32'd0, 32'd0};
    reset = 1'b1; en = 1'b1;
    drive(2'b00, 6'd0, 32'h3, 32'h4);
    pc = 32'h100; branch_offset = 32'h8;
    #1;
    tick();
    got = {alu_ctrl, alu_result, zero, pc_plus_4, branch_target};
    n_cmp++;
    if (got !== rst_exp) begin
      n_bad++;
      $display("FAIL reset_held got=%h exp=%h", got, rst_exp);
    end
    reset = 1'b0;
    #2;
    got = {alu_ctrl, alu_result, zero, pc_plus_4, branch_target};
    n_cmp++;
    if (got !== rst_exp) begin
      n_bad++;
      $display("FAIL reset_release_no_edge got=%h exp=%h", got, rst_exp);
    end
    @(negedge clk);
    tick();
    got = {alu_ctrl, alu_result, zero, pc_plus_4, branch_target};
    n_cmp++;
    if (got !== {4'b0010, 32'h7, 1'b0, 32'h104, 32'h10C}) begin
      n_bad++;
      $display("FAIL first_op_after_reset got=%h exp=%h", got,
               {4'b0010, 32'h7, 1'b0, 32'h104, 32'h10C});
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    got = {alu_ctrl, alu_result, zero, pc_plus_4, branch_target};
    n_cmp++;
    if (got !== rst_exp) begin
      n_bad++;
      $display("FAIL reset_async_mid_cycle got=%h exp=%h", got, rst_exp);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_rtype_sweep();
    logic [5:0]  fn  [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                             6'b101010, 6'b100111, 6'b000000};
    logic [3:0]  ec  [7] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001,
                             4'b0111, 4'b1100, 4'b0010};
    logic [31:0] er  [7] = '{32'h16, 32'h2, 32'h8, 32'hE,
                             32'h0, 32'hFFFFFFF1, 32'h16};
    en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(2'b10, fn[i], 32'hC, 32'hA);
      tick();
      n_cmp++;
      if (alu_ctrl !== ec[i]) begin
        n_bad++;
        $display("FAIL rtype_ctrl[%0d] got=%b exp=%b", i, alu_ctrl, ec[i]);
      end
      n_cmp++;
      if (alu_result !== er[i] || zero !== (er[i] == 32'd0)) begin
        n_bad++;
        $display("FAIL rtype_result[%0d] got=%h/%b exp=%h/%b", i, alu_result, zero,
                 er[i], er[i] == 32'd0);
      end
    end
    // funct only matters for op 10
    drive(2'b11, 6'b100010, 32'hC, 32'hA);
    tick();
    n_cmp++;
    if (alu_ctrl !== 4'b0001 || alu_result !== 32'hE) begin
      n_bad++;
      $display("FAIL op11_or got=%b/%h exp=0001/0000000e", alu_ctrl, alu_result);
    end
    drive(2'b00, 6'b100100, 32'h7FFFFFFF, 32'h1);
    tick();
    n_cmp++;
    if (alu_ctrl !== 4'b0010 || alu_result !== 32'h80000000 || zero !== 1'b0) begin
      n_bad++;
      $display("FAIL add_overflow got=%b/%h/%b exp=0010/80000000/0", alu_ctrl,
               alu_result, zero);
    end
  endtask

  task automatic test_branch_compare();
    en = 1'b1;
    drive(2'b01, 6'b100101, 32'h1234, 32'h1234);
    tick();
    n_cmp++;
    if (alu_ctrl !== 4'b0110 || alu_result !== 32'h0 || zero !== 1'b1) begin
      n_bad++;
      $display("FAIL beq_equal got=%b/%h/%b exp=0110/00000000/1", alu_ctrl, alu_result, zero);
    end
    drive(2'b01, 6'b100101, 32'h1234, 32'h1235);
    tick();
    n_cmp++;
    if (alu_result !== 32'hFFFFFFFF || zero !== 1'b0) begin
      n_bad++;
      $display("FAIL beq_differ got=%h/%b exp=ffffffff/0", alu_result, zero);
    end
  endtask

  task automatic test_signed_slt();
    logic [31:0] a [4] = '{32'hFFFFFFFF, 32'h1, 32'h5, 32'h80000000};
    logic [31:0] b [4] = '{32'h1, 32'hFFFFFFFF, 32'h5, 32'h0};
    logic [31:0] e [4] = '{32'h1, 32'h0, 32'h0, 32'h1};
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(2'b10, 6'b101010, a[i], b[i]);
      tick();
      n_cmp++;
      if (alu_result !== e[i] || zero !== (e[i] == 32'd0)) begin
        n_bad++;
        $display("FAIL slt[%0d] got=%h/%b exp=%h/%b", i, alu_result, zero, e[i], e[i] == 32'd0);
      end
    end
  endtask

  task automatic test_pc_adders();
    logic [31:0] p  [3] = '{32'h10, 32'hFFFFFFFC, 32'h0};
    logic [31:0] o  [3] = '{32'h20, 32'h0, 32'hFFFFFFF8};
    logic [31:0] e4 [3] = '{32'h14, 32'h0, 32'h4};
    logic [31:0] eb [3] = '{32'h34, 32'h0, 32'hFFFFFFFC};
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc = p[i];
      branch_offset = o[i];
      tick();
      n_cmp++;
      if (pc_plus_4 !== e4[i] || branch_target !== eb[i]) begin
        n_bad++;
        $display("FAIL pc_add[%0d] got=%h/%h exp=%h/%h", i, pc_plus_4, branch_target,
                 e4[i], eb[i]);
      end
    end
  endtask

  task automatic test_enable_hold();
    en = 1'b1;
    drive(2'b00, 6'd0, 32'h10, 32'h4);
    pc = 32'h40; branch_offset = 32'h10;
    tick();
    n_cmp++;
    if (alu_result !== 32'h14 || zero !== 1'b0 || pc_plus_4 !== 32'h44 ||
        branch_target !== 32'h54) begin
      n_bad++;
      $display("FAIL latency got=%h/%b/%h/%h exp=00000014/0/00000044/00000054",
               alu_result, zero, pc_plus_4, branch_target);
    end
    en = 1'b0;
    drive(2'b10, 6'b100010, 32'h4, 32'h4);
    pc = 32'hFFFFFFFC; branch_offset = 32'h100;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (alu_ctrl !== 4'b0010 || alu_result !== 32'h14 || zero !== 1'b0 ||
          pc_plus_4 !== 32'h44 || branch_target !== 32'h54) begin
        n_bad++;
        $display("FAIL hold[%0d] got=%b/%h/%b/%h/%h exp=0010/00000014/0/00000044/00000054",
                 i, alu_ctrl, alu_result, zero, pc_plus_4, branch_target);
      end
    end
    en = 1'b1;
    tick();
    n_cmp++;
    if (alu_ctrl !== 4'b0110 || alu_result !== 32'h0 || zero !== 1'b1 ||
        pc_plus_4 !== 32'h0 || branch_target !== 32'h100) begin
      n_bad++;
      $display("FAIL resume got=%b/%h/%b/%h/%h exp=0110/00000000/1/00000000/00000100",
               alu_ctrl, alu_result, zero, pc_plus_4, branch_target);
    end
  endtask

  initial begin
    test_reset();
    test_rtype_sweep();
    test_branch_compare();
    test_signed_slt();
    test_pc_adders();
    test_enable_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
